branch_predict_unit: RTL

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

---
 rtl/branch_predict_unit_pkg.sv | 23 ++
 rtl/branch_predict_unit_compare.sv | 35 +++
 rtl/branch_predict_unit.sv | 95 +++++++++
 3 files changed

// File: rtl/branch_predict_unit_pkg.sv
// Shared definitions for the branch prediction unit:
// branch condition codes, 2-bit counter states, index width.
package branch_predict_unit_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_e;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/branch_predict_unit_compare.sv
// Branch condition evaluator; legal is low for the
// two funct3 codes that are not conditional branches.
module branch_compare
  import branch_predict_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken,
  output logic            legal
);

  logic eq, lt_s, lt_u;

  assign eq   = rs1 == rs2;
  assign lt_s = $signed(rs1) < $signed(rs2);
  assign lt_u = rs1 < rs2;

  always_comb begin
    taken = 1'b0;
    legal = 1'b1;
    unique case (funct3)
      BEQ:     taken = eq;
      BNE:     taken = !eq;
      BLT:     taken = lt_s;
      BGE:     taken = !lt_s;
      BLTU:    taken = lt_u;
      BGEU:    taken = !lt_u;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal predictor: 2-bit counter table, EX-stage
// branch resolution and saturating perf counters.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_pred_taken,
  output logic            ex_taken,
  output logic            mispredict,
  output logic [CNT_W-1:0] perf_branches,
  output logic [CNT_W-1:0] perf_mispredicts
);

  localparam int IW = idx_w(BHT_ENTRIES);
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [1:0] bht_q [BHT_ENTRIES];
  logic [1:0] bht_d [BHT_ENTRIES];
  logic [CNT_W-1:0] br_q, br_d;
  logic [CNT_W-1:0] mp_q, mp_d;

  logic cmp_taken, cmp_legal, resolve;
  logic [IW-1:0] if_idx, ex_idx;
  logic [1:0] cur;

  branch_compare #(.XLEN(XLEN)) u_cmp (
    .funct3 (ex_funct3),
    .rs1    (ex_rs1),
    .rs2    (ex_rs2),
    .taken  (cmp_taken),
    .legal  (cmp_legal)
  );

  assign resolve    = ex_valid & ex_branch & cmp_legal;
  assign ex_taken   = resolve & cmp_taken;
  assign mispredict = resolve & (ex_taken != ex_pred_taken);

  assign if_idx = if_pc[IW+1:2];
  assign ex_idx = ex_pc[IW+1:2];

  // Registered-state read: no bypass from a same-cycle update.
  assign if_pred_taken = bht_q[if_idx][1];

  assign cur = bht_q[ex_idx];

  always_comb begin
    bht_d = bht_q;
    br_d  = br_q;
    mp_d  = mp_q;
    if (resolve) begin
      if (ex_taken && cur != ST)
        bht_d[ex_idx] = cur + 2'd1;
      else if (!ex_taken && cur != SNT)
        bht_d[ex_idx] = cur - 2'd1;
      if (br_q != CMAX)
        br_d = br_q + CNT_W'(1);
      if (mispredict && mp_q != CMAX)
        mp_d = mp_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++)
        bht_q[i] <= WNT;
      br_q <= '0;
      mp_q <= '0;
    end else begin
      bht_q <= bht_d;
      br_q  <= br_d;
      mp_q  <= mp_d;
    end
  end

  assign perf_branches    = br_q;
  assign perf_mispredicts = mp_q;

  logic unused_pc;
  assign unused_pc = ^{if_pc[XLEN-1:IW+2], if_pc[1:0],
                       ex_pc[XLEN-1:IW+2], ex_pc[1:0]};

endmodule
